// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with architectural HI/LO.
// Launches mult/multu/div/divu as multi-cycle ops. The full result is
// computed and staged at launch, then committed to HI/LO when the busy
// counter expires. mthi/mtlo write HI/LO directly when the unit is idle.
// Ports:
//   Clk, Rst        clock, async active-low reset
//   A, B            forwarded rs/rt operands
//   Start, MDU_Sel  launch request and op select (0 mult, 1 multu, 2 div, 3 divu)
//   HI_En, LO_En    mthi/mtlo write enables (HI/LO <= A)
//   MDU_Out_Sel     1 selects HI, 0 selects LO onto MDU_Out
//   Req             exception on the E-stage instruction; blocks new requests
//   Busy            operation in flight (decode of the counter)
//   MDU_Out         combinational HI/LO read port
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [2:0]  MDU_Sel,
  input  logic        HI_En,
  input  logic        LO_En,
  input  logic        MDU_Out_Sel,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] MDU_Out
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic [W-1:0]    hi_q, lo_q, hi_tmp, lo_tmp;
  logic [CW-1:0]   cnt;
  logic            dz_q;

  logic [2*W-1:0]  a_sx, b_sx, prod_s, prod_u;
  logic            is_signed;
  logic [W-1:0]    a_mag, b_mag, dvd, dvs, q_mag, r_mag, q_div, r_div;
  logic [W-1:0]    res_hi, res_lo;
  logic            res_dz;
  logic            launch;

  // Full result for the op currently selected; staged on the launch edge.
  always_comb begin
    a_sx      = {{W{A[W-1]}}, A};
    b_sx      = {{W{B[W-1]}}, B};
    prod_s    = a_sx * b_sx;
    prod_u    = {{W{1'b0}}, A} * {{W{1'b0}}, B};

    // One unsigned divider serves both div and divu via sign-magnitude.
    is_signed = (MDU_Sel == 3'd2);
    a_mag     = A[W-1] ? (~A + W'(1)) : A;
    b_mag     = B[W-1] ? (~B + W'(1)) : B;
    dvd       = is_signed ? a_mag : A;
    dvs       = is_signed ? b_mag : B;
    // Divisor forced nonzero; a zero-divide result is discarded anyway.
    if (dvs == '0) dvs = W'(1);
    q_mag     = dvd / dvs;
    r_mag     = dvd % dvs;
    q_div     = (is_signed && (A[W-1] ^ B[W-1])) ? (~q_mag + W'(1)) : q_mag;
    r_div     = (is_signed && A[W-1]) ? (~r_mag + W'(1)) : r_mag;

    res_hi    = '0;
    res_lo    = '0;
    res_dz    = 1'b0;
    case (MDU_Sel)
      3'd0:    {res_hi, res_lo} = prod_s;
      3'd1:    {res_hi, res_lo} = prod_u;
      3'd2,
      3'd3: begin
        res_hi = r_div;
        res_lo = q_div;
        res_dz = (B == '0);
      end
      default: ;
    endcase

    launch = Start & ~Req & ~Busy & ~MDU_Sel[2];
  end

  // Launch / countdown / commit, plus idle-time mthi/mtlo.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      dz_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      if (launch) begin
        hi_tmp <= res_hi;
        lo_tmp <= res_lo;
        dz_q   <= res_dz;
        cnt    <= MDU_Sel[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (cnt == CW'(1)) begin
        if (!dz_q) begin
          hi_q <= hi_tmp;
          lo_q <= lo_tmp;
        end
        cnt <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      // Busy excludes the commit edge above, so these never collide with it.
      if (!Busy && !Req) begin
        if (HI_En) hi_q <= A;
        if (LO_En) lo_q <= A;
      end
    end
  end

  assign Busy    = (cnt != '0);
  assign MDU_Out = MDU_Out_Sel ? hi_q : lo_q;

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit of the execute stage, downstream of the decode stage. It consumes the forwarded operands that decode resolves (`RD1_NEW`/`RD2_NEW`, carried through the D/E register) together with the MD control decoded for the instruction now in E. It performs multi-cycle mult/multu/div/divu and single-cycle mthi/mtlo, holds the architectural HI/LO registers, and exports `Busy` so decode can stall any MD-class instruction (`IsMD`) while an operation is in flight. `MDU_Out` feeds the E/M result path and ultimately the W-stage write-back mux.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: Busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: Busy cycles for div/divu.

Ports:
- `Clk`  input  1  Clock; all state updates on the rising edge.
- `Rst`  input  1  Reset, asynchronous, active-low; clears all state.
- `A`  input  32  Operand rs (forwarded value).
- `B`  input  32  Operand rt (forwarded value).
- `Start`  input  1  Launch the op selected by `MDU_Sel`; valid only for mult/multu/div/divu.
- `MDU_Sel`  input  3  Operation: 0=mult, 1=multu, 2=div, 3=divu; 4–7 are reserved and treated as no-op.
- `HI_En`  input  1  mthi: HI <= A.
- `LO_En`  input  1  mtlo: LO <= A.
- `MDU_Out_Sel`  input  1  1=HI, 0=LO; used by mfhi/mflo.
- `Req`  input  1  Exception/interrupt taken on the E-stage instruction. Suppresses `Start`, `HI_En` and `LO_En` this cycle.
- `Busy`  output  1  Operation in flight.
- `MDU_Out`  output  32  Combinational: selected HI or LO.

## Operation
State:
- `HI`, `LO`: 32-bit.
- `cnt`: 4-bit down-counter.
- `hi_tmp`, `lo_tmp`: 32-bit staged result.

Busy and launch:
- `Busy = (cnt != 0)`.
- Launch condition is `Start & ~Req & ~Busy`. On a launch edge, `hi_tmp`/`lo_tmp` are loaded with the full result from `A`/`B`, and `cnt` is loaded with `MULT_CYCLES` or `DIV_CYCLES`.

Result encoding:
- mult: {HI,LO} = signed A × signed B, 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div/divu: LO = quotient, rounded toward zero; HI = remainder, with the sign of the dividend (signed case).
- div of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B==0):
  - Busy still runs `DIV_CYCLES`.
  - HI/LO are left unchanged at commit; a per-op flag suppresses the commit.

Commit and counting:
- On an edge where `cnt==1`: HI <= `hi_tmp`, LO <= `lo_tmp` (unless the divide-by-zero flag is set), and `cnt <= 0`.
- Otherwise, while `cnt != 0`, `cnt` decrements each edge.

mthi/mtlo:
- When `HI_En & ~Req & ~Busy`, HI <= A at the edge.
- When `LO_En & ~Req & ~Busy`, LO <= A at the edge.
- Both may be asserted together.

Ignored requests:
- `Start`, `HI_En` and `LO_En` are ignored while `Busy=1`. Decode guarantees this by stalling on `Busy | Start` whenever `IsMD`; the unit must still hold state if violated.
- `Start` with `MDU_Sel` 4–7 is a no-op.

Req semantics:
- `Req` never aborts an in-flight operation. An op already launched commits normally, per MIPS semantics for an older instruction.

Reset:
- `HI=0`, `LO=0`, `cnt=0`, temps=0, so `Busy=0` and `MDU_Out=0`.
- Reset mid-operation discards the operation immediately (asynchronous), and HI/LO read 0.

## Timing
- Cycle 0: `Start` is high with the instruction in E.
- Cycles 1..N: `Busy=1`.
- Cycle N+1: `Busy=0`; new HI/LO are visible on `MDU_Out`.
  - mult: N=5.
  - div: N=10.
- A new `Start` is accepted in cycle N+1 at the earliest. Back-to-back ops therefore give Busy=1 for N cycles, one cycle low, then Busy again.
- mthi/mtlo: value is visible on `MDU_Out` in the cycle after the enable.
- `MDU_Out` has zero-cycle latency from `HI`/`LO`/`MDU_Out_Sel`. HI/LO never change mid-Busy; they update only at the commit edge.
- `Busy` is a registered-decode of `cnt` with no combinational path from `Start`. Decode must OR in `Start` itself for the cycle-0 stall.

## Test plan
- mult A=0xFFFFFFFE (-2), B=3, Start 1 cycle, then:
  - Busy is high for exactly 5 cycles.
  - Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu with the same operands: HI=0x2, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 → after 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1.
- Divide by zero:
  - Preload with mthi 0x1234, mtlo 0x5678.
  - div B=0 → Busy for 10 cycles; HI=0x1234 and LO=0x5678 are unchanged.
- `Start` and `HI_En` pulsed during Busy (cycle 3 of a mult) → both are ignored. The original mult result commits at cycle 6, and `cnt` is not reloaded.
- `Req=1` with `Start=1` → Busy stays 0 and HI/LO are unchanged. With `Req=1` during Busy, the in-flight op still commits.
- Assert `Rst` low asynchronously mid-division (cycle 4):
  - Immediately Busy=0, MDU_Out=0.
  - After release, mthi 0xA5A5A5A5 then MDU_Out_Sel=1 → 0xA5A5A5A5 in the next cycle.
